// File: rtl/pk_byte_unpacker.sv
// Unpacks an LSB-first byte stream of 13-bit coefficients into 26-bit even/odd pairs.
// A 40-bit accumulator absorbs bytes while fewer than 26 bits are held and emits a pair otherwise.
module pk_byte_unpacker #(
  parameter int N_PAIRS = 350,
  parameter int N_BYTES = 1138
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [25:0] pair,
  output logic        pair_valid,
  input  logic        pair_ready,
  output logic [8:0]  pair_count,
  output logic        done,
  output logic        pad_err
);
  localparam int BW = $clog2(N_BYTES + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_reg;
  logic [39:0]   acc_reg;
  logic [5:0]    fill_reg;
  logic [BW-1:0] bytes_reg;
  logic [8:0]    count_reg;
  logic          done_reg;
  logic          pad_reg;

  logic          byte_fire;
  logic          pair_fire;
  logic          last_pair;
  logic [39:0]   acc_shifted;

  // Handshake qualifiers depend on registers only, so the two fires can never coincide.
  assign byte_ready  = (state_reg == RUN) && (fill_reg < 6'd26) && (bytes_reg < BW'(N_BYTES));
  assign pair_valid  = (state_reg == RUN) && (fill_reg >= 6'd26);
  assign pair        = acc_reg[25:0];
  assign pair_count  = count_reg;
  assign done        = done_reg;
  assign pad_err     = pad_reg;

  assign byte_fire   = byte_valid && byte_ready;
  assign pair_fire   = pair_valid && pair_ready;
  assign acc_shifted = acc_reg >> 26;
  assign last_pair   = pair_fire && (count_reg == 9'(N_PAIRS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      fill_reg  <= '0;
      bytes_reg <= '0;
      count_reg <= '0;
      done_reg  <= 1'b0;
      pad_reg   <= 1'b0;
    end else if (start && (state_reg != RUN)) begin
      state_reg <= RUN;
      acc_reg   <= '0;
      fill_reg  <= '0;
      bytes_reg <= '0;
      count_reg <= '0;
      done_reg  <= 1'b0;
      pad_reg   <= 1'b0;
    end else if (state_reg == RUN) begin
      if (byte_fire) begin
        // Bits above fill are always zero, so OR-ing places the byte at acc[fill+7:fill].
        acc_reg   <= acc_reg | (40'(byte_in) << fill_reg);
        fill_reg  <= fill_reg + 6'd8;
        bytes_reg <= bytes_reg + BW'(1);
      end else if (pair_fire) begin
        acc_reg  <= acc_shifted;
        fill_reg <= fill_reg - 6'd26;
        if (count_reg != 9'(N_PAIRS))
          count_reg <= count_reg + 9'd1;
        if (last_pair) begin
          state_reg <= DONE;
          done_reg  <= 1'b1;
          pad_reg   <= (acc_shifted[3:0] != 4'd0);
        end
      end
    end else if (state_reg != DONE) begin
      state_reg <= IDLE;
    end
  end

endmodule

// File: doc/pk_byte_unpacker.md
PK_BYTE_UNPACKER -- requirements
Module: pk_byte_unpacker

Interface
REQ-001 SHALL have parameter N_PAIRS, default 350, meaning the number of 13-bit coefficient pairs extracted (700 coefficients of the packed HRSS public key).
REQ-002 SHALL have parameter N_BYTES, default 1138, meaning the number of packed input bytes consumed per run (ceil(700*13/8)).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle pulse that begins a run.
REQ-006 SHALL have port byte_in, input, 8, packed public-key byte, LSB first in the bit stream.
REQ-007 SHALL have port byte_valid, input, 1, meaning byte_in is valid.
REQ-008 SHALL have port byte_ready, output, 1, meaning the block accepts byte_in this cycle.
REQ-009 SHALL have port pair, output, 26, where [12:0] is the even coefficient and [25:13] is the odd coefficient, matching the 26-bit h bus of unpack_rq0.
REQ-010 SHALL have port pair_valid, output, 1, meaning pair is valid.
REQ-011 SHALL have port pair_ready, input, 1, meaning the downstream consumer takes pair this cycle.
REQ-012 SHALL have port pair_count, output, 9, giving the number of pairs delivered so far.
REQ-013 SHALL have port done, output, 1, a level that is high once all N_PAIRS pairs have been delivered.
REQ-014 SHALL have port pad_err, output, 1, high when the 4 trailing pad bits are nonzero.

Function
REQ-015 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE when the N_PAIRS-th pair is accepted; DONE -> RUN on start; start in RUN is ignored.
REQ-016 SHALL hold a bit accumulator acc[39:0] and a fill counter fill[5:0] (bits held, 0..33).
REQ-017 On start, SHALL clear acc, fill, pair_count, byte counter, done and pad_err in the same edge.
REQ-018 byte_ready SHALL equal (state==RUN) && (fill<26) && (bytes_taken<N_BYTES), decoded combinationally from registers only.
REQ-019 On a byte handshake (byte_valid && byte_ready), SHALL write byte_in into acc[fill+7:fill], add 8 to fill, and increment bytes_taken.
REQ-020 pair_valid SHALL equal (state==RUN) && (fill>=26); pair SHALL equal acc[25:0].
REQ-021 On a pair handshake (pair_valid && pair_ready), SHALL shift acc right by 26, subtract 26 from fill, and increment pair_count.
REQ-022 Byte and pair handshakes SHALL be mutually exclusive by construction (fill<26 vs fill>=26), so fill never exceeds 33 and never underflows.
REQ-023 pair and pair_valid SHALL hold stable while pair_ready is low.
REQ-024 byte_valid without byte_ready SHALL have no effect; a byte SHALL be neither lost nor duplicated.
REQ-025 Latency: with byte_valid continuously high from the first RUN cycle, pair_valid SHALL rise on the cycle after the 4th byte accept.
REQ-026 Steady-state throughput SHALL be 13 bytes per 4 pairs, with no idle cycles when both sides are always ready.
REQ-027 On the N_PAIRS-th pair handshake, the FSM SHALL enter DONE and done SHALL go high the next cycle; at that point bytes_taken==N_BYTES and fill==4.
REQ-028 On entry to DONE, pad_err SHALL be registered as (acc[3:0]!=0) evaluated after the final shift.
REQ-029 In DONE, byte_ready and pair_valid SHALL be 0, while done, pad_err and pair_count hold.
REQ-030 pair_count SHALL saturate at N_PAIRS.

Reset
REQ-031 When rst is low, SHALL force immediately state=IDLE, acc=0, fill=0, pair_count=0, bytes_taken=0, done=0, pad_err=0, byte_ready=0 and pair_valid=0.
REQ-032 Reset asserted mid-RUN SHALL abort the run, and no pair SHALL be emitted until the next start.
REQ-033 Deassertion SHALL be synchronized by the instantiating unit; the block itself contains no reset synchronizer.

Verification
REQ-034 SHALL test a directed stream: byte0=0x01, byte1=0x20, all other bytes 0x00 -> first pair even=13'h0001 and odd=13'h0001; the remaining 349 pairs are 0; done=1; pad_err=0.
REQ-035 SHALL test all 1138 bytes = 0xFF -> 350 pairs of 26'h3FFFFFF, done=1, pad_err=1, pair_count=350.
REQ-036 SHALL test random bytes with random byte_valid/pair_ready gaps -> the pair sequence matches a reference model (coefficient i = bits 13i..13i+12 of the LSB-first stream), with no loss or duplication.
REQ-037 SHALL test pair_ready held low for 10 cycles with fill=33 -> byte_ready=0 and pair stable throughout; on release, streaming resumes.
REQ-038 SHALL test rst pulsed low after 100 pairs -> all outputs 0 immediately; a new start followed by a full stream yields exactly 350 correct pairs.
REQ-039 SHALL test start pulsed in RUN -> it is ignored; start in DONE -> counters clear and a second run completes correctly.
